// File: rtl/led_blink_bank.sv
// Bank of independent LED channels (off / on / blink / one-shot) timed by a shared 1 ms prescaler.
// Optional LED_BRIGHT_EN adds a BRIGHT input and an 8-bit PWM dimmer on lit channels.
module led_blink_bank #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MS_W     = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_N,
  input  logic [2*CHANNELS-1:0]    MODE,
  input  logic [MS_W*CHANNELS-1:0] HALF_MS,
`ifdef LED_BRIGHT_EN
  input  logic [8*CHANNELS-1:0]    BRIGHT,
`endif
  output logic [CHANNELS-1:0]      LED,
  output logic [CHANNELS-1:0]      LED_N,
  output logic                     TICK
);

  localparam int unsigned DIV = CLK_HZ / 1000;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  logic [PW-1:0]                  presc_q, presc_d;
  logic                           tick_q, tick_d;
  logic [CHANNELS-1:0][MS_W-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0][MS_W-1:0]  lim_c;
  logic [CHANNELS-1:0][1:0]       mode_q, mode_d;
  logic [CHANNELS-1:0]            phase_q, phase_d;
  logic [CHANNELS-1:0]            done_q, done_d;
  logic [CHANNELS-1:0]            led_q, led_d;
  logic [CHANNELS-1:0]            led_n_q;
  logic [CHANNELS-1:0]            lit_c;
  logic [CHANNELS-1:0]            pwm_on_c;

  // Prescaler; tick_q mirrors "count == DIV-1" so it is high in exactly that cycle
  always_comb begin
    presc_d = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + PW'(1);
    tick_d  = (presc_d == PW'(DIV - 1));
  end

`ifdef LED_BRIGHT_EN
  logic [7:0] pwm_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) pwm_q <= '0;
    else          pwm_q <= pwm_q + 8'(1);
  end

  always_comb begin
    pwm_on_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      pwm_on_c[i] = (pwm_q < BRIGHT[8*i +: 8]);
    end
  end
`else
  assign pwm_on_c = '1;
`endif

  // Per-channel next state; a mode change wins over a coincident tick
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    done_d  = done_q;
    mode_d  = MODE;
    lim_c   = '0;
    lit_c   = '0;
    led_d   = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      lim_c[i] = (HALF_MS[MS_W*i +: MS_W] == '0) ? '0
                                                 : HALF_MS[MS_W*i +: MS_W] - MS_W'(1);
      if (MODE[2*i +: 2] != mode_q[i]) begin
        cnt_d[i]   = '0;
        phase_d[i] = 1'b1;
        done_d[i]  = 1'b0;
      end else begin
        case (mode_e'(mode_q[i]))
          MODE_BLINK: begin
            if (tick_q) begin
              if (cnt_q[i] >= lim_c[i]) begin
                phase_d[i] = ~phase_q[i];
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + MS_W'(1);
              end
            end
          end
          MODE_ONESHOT: begin
            if (tick_q && !done_q[i]) begin
              if (cnt_q[i] >= lim_c[i]) begin
                done_d[i] = 1'b1;
                cnt_d[i]  = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + MS_W'(1);
              end
            end
          end
          default: cnt_d[i] = '0;
        endcase
      end

      // LED is driven from the registered state, hence one clock behind it
      case (mode_e'(mode_q[i]))
        MODE_OFF:     lit_c[i] = 1'b0;
        MODE_ON:      lit_c[i] = 1'b1;
        MODE_BLINK:   lit_c[i] = phase_q[i];
        MODE_ONESHOT: lit_c[i] = ~done_q[i];
        default:      lit_c[i] = 1'b0;
      endcase
      led_d[i] = lit_c[i] & pwm_on_c[i];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
      phase_q <= '0;
      done_q  <= '0;
      led_q   <= '0;
      led_n_q <= '1;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      led_q   <= led_d;
      led_n_q <= ~led_d;
    end
  end

  assign LED   = led_q;
  assign LED_N = led_n_q;
  assign TICK  = tick_q;

endmodule

// File: doc/led_blink_bank.md
LED_BLINK_BANK -- requirements
Module: led_blink_bank

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz; legal values are multiples of 1000 and at least 2000.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent LED channels; legal range 1..16.
REQ-003 SHALL have parameter MS_W, default 16, width of each per-channel half-period field in milliseconds.
REQ-004 Port CLOCK_50  input  1  single system clock; all logic on rising edge.
REQ-005 Port RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-006 Port MODE  input  2*CHANNELS  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 steady on, 10 blink, 11 one-shot.
REQ-007 Port HALF_MS  input  MS_W*CHANNELS  per-channel half-period or pulse length in ms, channel i at [MS_W*i+MS_W-1:MS_W*i].
REQ-008 Port LED  output  CHANNELS  registered LED drive, 1 = lit.
REQ-009 Port LED_N  output  CHANNELS  bitwise complement of LED, registered in the same cycle.
REQ-010 Port TICK  output  1  one-cycle pulse once per millisecond, for debug and chaining.

Function
REQ-011 Shared prescaler SHALL count 0..CLK_HZ/1000-1 and wrap to 0; TICK SHALL be high for exactly the cycle in which the count equals CLK_HZ/1000-1.
REQ-012 Each channel SHALL have a registered ms counter of MS_W bits, a phase bit and a done bit.
REQ-013 Effective half-period SHALL be HALF_MS, or 1 when HALF_MS is 0.
REQ-014 A MODE change on a channel, detected against its registered previous value, SHALL clear the ms counter, set phase to 1 and clear done in the next cycle, independent of TICK.
REQ-015 Mode 00: LED bit SHALL be 0; ms counter SHALL hold at 0.
REQ-016 Mode 01: LED bit SHALL be 1; ms counter SHALL hold at 0.
REQ-017 Mode 10: on TICK, if counter >= effective half-period-1, the phase SHALL toggle and the counter SHALL clear; otherwise the counter SHALL increment; LED bit SHALL equal phase.
REQ-018 Mode 11: LED bit SHALL be 1 from mode entry until the counter reaches effective half-period-1 on a TICK; done SHALL then set and LED SHALL stay 0 until the next mode change.
REQ-019 A HALF_MS change without a MODE change SHALL NOT reset the counter; the new value SHALL take effect at the next compare, and a counter already beyond it SHALL cause a toggle on the next TICK.
REQ-020 A mode change coincident with TICK SHALL give the mode change priority; that TICK SHALL be ignored for that channel.
REQ-021 LED SHALL update one clock after the internal phase, done or mode state that drives it; LED_N SHALL always equal ~LED.
REQ-022 Channels SHALL be fully independent; no channel's state SHALL affect another's.

Reset
REQ-023 While RESET_N is low: prescaler, all ms counters, phase, done and previous-mode registers SHALL be 0; LED SHALL be all 0; LED_N SHALL be all 1; TICK SHALL be 0.
REQ-024 After RESET_N deasserts, the first TICK SHALL occur CLK_HZ/1000 clocks later; registered previous mode 00 SHALL make any non-00 MODE count as a mode change.
REQ-025 Reset asserted mid-blink or mid-one-shot SHALL abort immediately with no residual state.

Configuration
REQ-026 Macro LED_BRIGHT_EN: when defined, SHALL add input BRIGHT, width 8*CHANNELS, and a free-running 8-bit PWM counter; a lit LED bit SHALL be driven high only while the PWM count < BRIGHT[i], giving duty BRIGHT/256; BRIGHT=0 SHALL keep the LED dark.
REQ-027 Without LED_BRIGHT_EN, the BRIGHT port and the PWM counter SHALL NOT exist, and a lit LED SHALL be a constant 1.

Verification (CLK_HZ=10000, so 10 clocks/ms; CHANNELS=4)
REQ-028 Reset, then ch0 MODE=10, HALF_MS=3 -> LED[0] rises 2 clocks after MODE is applied, then toggles every 30 clocks; TICK period is exactly 10 clocks.
REQ-029 ch1 MODE=11, HALF_MS=5 -> LED[1] high for 5 TICK intervals, then low permanently; rewriting MODE 00->11 retriggers the pulse.
REQ-030 ch2 MODE=10, HALF_MS=0 -> toggles every TICK, i.e. every 10 clocks; ch3 MODE=01 -> constant 1; LED_N == ~LED every cycle.
REQ-031 Change ch0 MODE on a TICK cycle -> counter restarts and that TICK causes no toggle; assert RESET_N low mid-period -> LED=0 and LED_N=all 1 within the same cycle, asynchronously.
REQ-032 With LED_BRIGHT_EN and BRIGHT[7:0]=64, ch0 MODE=01 -> LED[0] high 64 of every 256 clocks; BRIGHT=0 -> LED[0] always 0.
